// File: rtl/rotate_pkg.sv
// Shared widths and FSM state type for the rotate arbiter.
package rotate_pkg;

    localparam int DATA_W = 8;
    localparam int AMT_W  = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/rotate_arbiter_if.sv
// Requester/arbiter handshake bundle: two request ports plus the shared result port.
interface rotate_arbiter_if;
    import rotate_pkg::*;

    logic              req0;
    logic              req1;
    logic [DATA_W-1:0] in0;
    logic [DATA_W-1:0] in1;
    logic [AMT_W-1:0]  by0;
    logic [AMT_W-1:0]  by1;
    logic              lr0;
    logic              lr1;
    logic              gnt0;
    logic              gnt1;
    logic              busy;
    logic              done;
    logic              done_id;
    logic [DATA_W-1:0] out;

    modport master (
        output req0, req1, in0, in1, by0, by1, lr0, lr1,
        input  gnt0, gnt1, busy, done, done_id, out
    );

    modport slave (
        input  req0, req1, in0, in1, by0, by1, lr0, lr1,
        output gnt0, gnt1, busy, done, done_id, out
    );

endinterface

// File: rtl/rotate8.sv
// Combinational barrel rotator: dir 0 rotates left (msb wraps to bit 0), dir 1 rotates right.
module rotate8
    import rotate_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [AMT_W-1:0]  amount,
    input  logic              dir,
    output logic [DATA_W-1:0] result
);

    // DATA_W is 2**AMT_W, so the source index wraps naturally at AMT_W bits.
    always_comb begin
        result = '0;
        for (int i = 0; i < DATA_W; i++) begin
            logic [AMT_W-1:0] src;
            src       = dir ? (AMT_W'(i) + amount) : (AMT_W'(i) - amount);
            result[i] = data[src];
        end
    end

endmodule

// File: rtl/rotate_arbiter.sv
// Two-requester round-robin rotate unit; define ROTATE_FAST_EN for the single-pass build.
//
// state | meaning
// IDLE  | waiting for a request; captures the round-robin winner
// SHIFT | rotating q one place per edge until cnt reaches zero
module rotate_arbiter
    import rotate_pkg::*;
(
    input  logic             CK,
    input  logic             RS,
    rotate_arbiter_if.slave  bus
);

    state_t            state;
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] out_r;
    logic [AMT_W-1:0]  cnt;
    logic              dir;
    logic              owner;
    logic              last;
    logic              gnt0_r;
    logic              gnt1_r;
    logic              done_r;
    logic              done_id_r;

    logic              pick1;
    logic [DATA_W-1:0] win_in;
    logic [AMT_W-1:0]  win_by;
    logic              win_lr;
    logic [DATA_W-1:0] rot_data;
    logic [AMT_W-1:0]  rot_amt;
    logic              rot_dir;
    logic [DATA_W-1:0] rot_q;

    // On a tie requester 1 wins only if requester 0 was granted last.
    assign pick1  = bus.req1 && (!bus.req0 || !last);
    assign win_in = pick1 ? bus.in1 : bus.in0;
    assign win_by = pick1 ? bus.by1 : bus.by0;
    assign win_lr = pick1 ? bus.lr1 : bus.lr0;

`ifdef ROTATE_FAST_EN
    assign rot_data = win_in;
    assign rot_amt  = win_by;
    assign rot_dir  = win_lr;
`else
    assign rot_data = q;
    assign rot_amt  = AMT_W'(1);
    assign rot_dir  = dir;
`endif

    rotate8 u_rotate8 (
        .data   (rot_data),
        .amount (rot_amt),
        .dir    (rot_dir),
        .result (rot_q)
    );

    always_ff @(posedge CK) begin
        if (RS) begin
            state     <= IDLE;
            q         <= '0;
            cnt       <= '0;
            dir       <= 1'b0;
            owner     <= 1'b0;
            last      <= 1'b1;
            out_r     <= '0;
            gnt0_r    <= 1'b0;
            gnt1_r    <= 1'b0;
            done_r    <= 1'b0;
            done_id_r <= 1'b0;
        end else begin
            gnt0_r <= 1'b0;
            gnt1_r <= 1'b0;
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        owner  <= pick1;
                        last   <= pick1;
                        gnt0_r <= !pick1;
                        gnt1_r <= pick1;
                        dir    <= win_lr;
`ifdef ROTATE_FAST_EN
                        q      <= rot_q;
                        cnt    <= '0;
`else
                        q      <= win_in;
                        cnt    <= win_by;
`endif
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        q   <= rot_q;
                        cnt <= cnt - 1'b1;
                    end else begin
                        out_r     <= q;
                        done_r    <= 1'b1;
                        done_id_r <= owner;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt0    = gnt0_r;
    assign bus.gnt1    = gnt1_r;
    assign bus.busy    = (state == SHIFT);
    assign bus.done    = done_r;
    assign bus.done_id = done_id_r;
    assign bus.out     = out_r;

endmodule

// File: tb/tb_rotate_arbiter.sv
// Self-checking bench for rotate_arbiter: vector table through a scoreboard plus tie, busy and reset sequences.
module tb_rotate_arbiter;
    import rotate_pkg::*;

    logic CK = 1'b0;
    logic RS;

    rotate_arbiter_if bus ();

    rotate_arbiter dut (
        .CK  (CK),
        .RS  (RS),
        .bus (bus)
    );

    always #5 CK = ~CK;

    typedef struct {
        logic       sel;
        logic [7:0] din;
        logic [2:0] amt;
        logic       lr;
        logic [7:0] exp_out;
    } vec_t;

    typedef struct {
        logic [7:0] out;
        logic       id;
        int         lat;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_lat(input logic [2:0] amt);
`ifdef ROTATE_FAST_EN
        return 1;
`else
        return int'(amt) + 1;
`endif
    endfunction

    task automatic clear_reqs();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
    endtask

    task automatic run_op(input vec_t v);
        exp_t e;
        exp_t got;
        int   lat;
        int   busy_cyc;
        logic seen;
        logic extra_gnt;
        @(negedge CK);
        if (v.sel) begin
            bus.req1 = 1'b1; bus.in1 = v.din; bus.by1 = v.amt; bus.lr1 = v.lr;
        end else begin
            bus.req0 = 1'b1; bus.in0 = v.din; bus.by0 = v.amt; bus.lr0 = v.lr;
        end
        e.out = v.exp_out;
        e.id  = v.sel;
        e.lat = exp_lat(v.amt);
        sb.push_back(e);
        @(negedge CK);
        chk("gnt_winner", v.sel ? bus.gnt1 : bus.gnt0, 1);
        chk("gnt_loser",  v.sel ? bus.gnt0 : bus.gnt1, 0);
        clear_reqs();
        busy_cyc  = bus.busy ? 1 : 0;
        lat       = 0;
        seen      = 1'b0;
        extra_gnt = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge CK);
            lat++;
            if (bus.gnt0 || bus.gnt1) extra_gnt = 1'b1;
            if (bus.done) seen = 1'b1;
            else if (bus.busy) busy_cyc++;
        end
        chk("gnt_one_cycle", extra_gnt, 0);
        if (!seen) begin
            chk("done_timeout", 0, 1);
            return;
        end
        if (sb.size() == 0) begin
            chk("sb_empty", 0, 1);
            return;
        end
        got = sb.pop_front();
        chk("out", bus.out, got.out);
        chk("done_id", bus.done_id, got.id);
        chk("latency", lat, got.lat);
        chk("busy_cycles", busy_cyc, got.lat);
        chk("busy_in_done", bus.busy, 0);
        @(negedge CK);
        chk("done_pulse", bus.done, 0);
        chk("out_hold", bus.out, got.out);
        chk("id_hold", bus.done_id, got.id);
    endtask

    initial begin
        int   grants [4];
        int   ng;
        logic prev_done;
        int   lat;
        logic seen;
        logic saw_gnt1;
        exp_t e;

        vecs[0] = '{1'b0, 8'h81, 3'd1, 1'b0, 8'h03};
        vecs[1] = '{1'b1, 8'h81, 3'd1, 1'b1, 8'hC0};
        vecs[2] = '{1'b0, 8'hA5, 3'd7, 1'b0, 8'hD2};
        vecs[3] = '{1'b1, 8'h5A, 3'd0, 1'b0, 8'h5A};
        vecs[4] = '{1'b0, 8'h01, 3'd5, 1'b0, 8'h20};
        vecs[5] = '{1'b1, 8'h3C, 3'd3, 1'b1, 8'h87};
        vecs[6] = '{1'b0, 8'h96, 3'd4, 1'b1, 8'h69};
        vecs[7] = '{1'b1, 8'h80, 3'd7, 1'b1, 8'h01};

        // Reset with both requests already high; they stay high into the tie sequence.
        RS = 1'b1;
        bus.req0 = 1'b1; bus.in0 = 8'h11; bus.by0 = 3'd0; bus.lr0 = 1'b0;
        bus.req1 = 1'b1; bus.in1 = 8'h22; bus.by1 = 3'd0; bus.lr1 = 1'b0;
        repeat (2) @(posedge CK);
        @(negedge CK);
        chk("rst_gnt0", bus.gnt0, 0);
        chk("rst_gnt1", bus.gnt1, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_done_id", bus.done_id, 0);
        chk("rst_out", bus.out, 0);
        RS = 1'b0;

        ng = 0;
        prev_done = 1'b0;
        for (int k = 0; k < 60 && ng < 4; k++) begin
            @(negedge CK);
            if (bus.gnt0 && bus.gnt1) chk("tie_double_gnt", 1, 0);
            if (prev_done) chk("tie_gnt_after_done", bus.gnt0 | bus.gnt1, 1);
            if (bus.gnt0 || bus.gnt1) begin
                grants[ng] = bus.gnt1 ? 1 : 0;
                ng++;
            end
            prev_done = bus.done;
        end
        clear_reqs();
        chk("tie_grant_count", ng, 4);
        for (int i = 0; i < ng; i++) chk("tie_order", grants[i], i % 2);
        repeat (4) @(negedge CK);
        chk("tie_idle", bus.busy, 0);

        // Requester 1 raises while requester 0 is in flight; it must be ignored.
        bus.req0 = 1'b1; bus.in0 = 8'hC3; bus.by0 = 3'd7; bus.lr0 = 1'b0;
        e.out = 8'hE1; e.id = 1'b0; e.lat = exp_lat(3'd7);
        sb.push_back(e);
        @(negedge CK);
        chk("busy_gnt0", bus.gnt0, 1);
        bus.req0 = 1'b0;
        bus.req1 = 1'b1; bus.in1 = 8'hFF; bus.by1 = 3'd2; bus.lr1 = 1'b1;
        lat = 0;
        seen = 1'b0;
        saw_gnt1 = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge CK);
            lat++;
            if (k == 0) bus.req1 = 1'b0;
            if (bus.gnt1) saw_gnt1 = 1'b1;
            if (bus.done) seen = 1'b1;
        end
        chk("busy_ignored", saw_gnt1, 0);
        chk("busy_done_seen", seen, 1);
        if (seen && sb.size() != 0) begin
            e = sb.pop_front();
            chk("busy_out", bus.out, e.out);
            chk("busy_done_id", bus.done_id, e.id);
            chk("busy_latency", lat, e.lat);
        end
        repeat (3) @(negedge CK);
        chk("busy_no_late_gnt", bus.gnt1, 0);
        chk("busy_idle", bus.busy, 0);

        for (int i = 0; i < 8; i++) run_op(vecs[i]);

        // Reset in the cycle right after capture aborts the operation.
        @(negedge CK);
        bus.req0 = 1'b1; bus.in0 = 8'hFF; bus.by0 = 3'd7; bus.lr0 = 1'b1;
        @(negedge CK);
        chk("abort_gnt0", bus.gnt0, 1);
        chk("abort_busy", bus.busy, 1);
        clear_reqs();
        RS = 1'b1;
        @(negedge CK);
        RS = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge CK);
            if (bus.done) seen = 1'b1;
        end
        chk("abort_no_done", seen, 0);
        chk("abort_out", bus.out, 0);
        chk("abort_busy_low", bus.busy, 0);
        chk("abort_done_id", bus.done_id, 0);
        chk("abort_sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/rotate_arbiter.md
ROTATE_ARBITER -- requirements
Module: rotate_arbiter

Interface
REQ-001 SHALL have ports CK input 1, rising-edge clock; RS input 1, synchronous active-high reset.
REQ-002 SHALL have ports req0 / req1 input 1, rotate request from requester 0 / 1.
REQ-003 SHALL have ports in0 / in1 input 8, operand; by0 / by1 input 3, rotate amount; lr0 / lr1 input 1, direction (0 left, 1 right).
REQ-004 SHALL have ports gnt0 / gnt1 output 1, one-cycle grant pulse; busy output 1, operation in flight.
REQ-005 SHALL have ports done output 1, one-cycle completion pulse; done_id output 1, owner of completed result; out output 8, result.

Function
REQ-006 SHALL implement an FSM with states IDLE and SHIFT.
REQ-007 IDLE: if any reqN is high at a rising CK edge, SHALL capture the winner's inN, byN and lrN into working register q, counter cnt and dir, record the owner, and enter SHIFT.
REQ-008 gntN SHALL be high for exactly the one cycle following the capture edge; operands are sampled only at that edge.
REQ-009 Requesters SHALL drop reqN on seeing gntN; a req still high in IDLE SHALL be a new request.
REQ-010 Arbitration SHALL be round-robin: single request wins; with both high, the requester not granted last wins; the last-grant pointer updates at each capture.
REQ-011 SHIFT with cnt != 0: each edge SHALL rotate q by one position in dir and decrement cnt.
REQ-012 SHIFT with cnt == 0: the edge SHALL load out <= q, set done = 1, set done_id = owner, and return to IDLE.
REQ-013 Left rotate: bit 7 moves to bit 0. Right rotate: bit 0 moves to bit 7.
REQ-014 by = 0 SHALL return the operand unchanged.
REQ-015 Serial latency: done SHALL be high in the cycle after capture edge + by + 1 edges; the next capture SHALL be possible at the edge ending the done cycle.
REQ-016 busy SHALL be high exactly while state is SHIFT.
REQ-017 done SHALL be high for one cycle only; out and done_id SHALL hold their values until the next completion.
REQ-018 Requests arriving while busy SHALL be ignored; no queueing.

Reset
REQ-019 RS high at a CK edge SHALL override all other activity and set: state IDLE; q, cnt, out = 0; done, done_id, gnt0, gnt1, busy = 0; last-grant pointer = 1, so req0 wins the first tie.
REQ-020 RS during SHIFT SHALL abort the operation with no done pulse.

Configuration
REQ-021 Macro ROTATE_FAST_EN defined: capture SHALL load q with the operand already rotated by byN and set cnt = 0, so done always follows capture by exactly one edge.
REQ-022 Macro ROTATE_FAST_EN undefined: the block SHALL use the serial one-position-per-cycle behaviour of REQ-011.
REQ-023 Interface and handshake SHALL be identical in both builds.

Structure
REQ-024 Package rotate_pkg SHALL hold DATA_W = 8, AMT_W = 3, and the state enum (IDLE, SHIFT).
REQ-025 SHALL instantiate one combinational sub-module rotate8 (data, amount, dir -> rotated data), used with amount 1 in the serial build and amount byN in the fast build.

Verification
REQ-026 Reset, then req0 with in0 = 8'h81, by0 = 1, lr0 = 0 -> gnt0 pulse, done after 2 edges, out = 8'h03, done_id = 0.
REQ-027 req1 with in1 = 8'h81, by1 = 1, lr1 = 1 -> out = 8'hC0, done_id = 1.
REQ-028 Serial build, in0 = 8'hA5, by0 = 7, left -> done 8 edges after capture, out = 8'hD2, busy high for 8 cycles.
REQ-029 req0 and req1 held high continuously from reset -> grants alternate 0, 1, 0, 1; never two grants of the same requester back-to-back.
REQ-030 by = 0 with in = 8'h5A -> out = 8'h5A; RS asserted mid-SHIFT -> no done pulse, out = 8'h00, busy = 0.
REQ-031 Fast build, by = 5, left, in = 8'h01 -> out = 8'h20, done exactly 1 edge after capture.
